// File: rtl/turn_controller.sv
// turn_controller: sequences one artillery turn per player
// (aim -> launch -> flight -> settle -> swap) and drives the bomb's launch inputs.
module turn_controller #(
    parameter int unsigned KEY_REPEAT    = 8,
    parameter int unsigned SETTLE_FRAMES = 30,
    parameter int unsigned MAX_FLIGHT    = 600,
    parameter int unsigned ANGLE_P0      = 6,
    parameter int unsigned ANGLE_P1      = 2,
    parameter int unsigned POWER_INIT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic       ang_up,
    input  logic       ang_dn,
    input  logic       pwr_up,
    input  logic       pwr_dn,
    input  logic       exploded,
    input  logic [9:0] tank0_x,
    input  logic [9:0] tank0_y,
    input  logic [9:0] tank1_x,
    input  logic [9:0] tank1_y,
    output logic       launch,
    output logic [9:0] launchX,
    output logic [9:0] launchY,
    output logic [3:0] angle,
    output logic [2:0] power,
    output logic       player,
    output logic [2:0] phase,
    output logic       timeout,
    output logic [7:0] turn_count
);

    localparam int unsigned RPT_W   = (KEY_REPEAT > 1) ? $clog2(KEY_REPEAT) : 1;
    localparam int unsigned FRM_LIM = (MAX_FLIGHT > SETTLE_FRAMES) ? MAX_FLIGHT : SETTLE_FRAMES;
    localparam int unsigned FRM_W   = $clog2(FRM_LIM + 1);
    localparam logic [3:0]  ANGLE_MAX = 4'd8;
    localparam logic [2:0]  POWER_MAX = 3'd7;

    typedef enum logic [2:0] {
        S_AIM    = 3'd0,
        S_LAUNCH = 3'd1,
        S_FLIGHT = 3'd2,
        S_SETTLE = 3'd3,
        S_SWAP   = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_fire_prev;
    logic [RPT_W-1:0] r_ang_rpt, w_ang_rpt_nxt;
    logic [RPT_W-1:0] r_pwr_rpt, w_pwr_rpt_nxt;
    logic [FRM_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic             r_seen_low, w_seen_low_nxt;
    logic [3:0]       r_angle0, r_angle1, w_angle0_nxt, w_angle1_nxt;
    logic [2:0]       r_power0, r_power1, w_power0_nxt, w_power1_nxt;
    logic [3:0]       w_angle_act, w_angle_new;
    logic [2:0]       w_power_act, w_power_new;
    logic             r_player, w_player_nxt;
    logic [7:0]       r_turn_count, w_turn_count_nxt;
    logic             r_launch, w_launch_nxt;
    logic [9:0]       r_launch_x, r_launch_y, w_launch_x_nxt, w_launch_y_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             w_fire_edge, w_boom, w_ang_single, w_pwr_single;

    assign w_fire_edge  = fire & ~r_fire_prev;
    assign w_boom       = r_seen_low & exploded;
    assign w_ang_single = ang_up ^ ang_dn;
    assign w_pwr_single = pwr_up ^ pwr_dn;
    assign w_angle_act  = r_player ? r_angle1 : r_angle0;
    assign w_power_act  = r_player ? r_power1 : r_power0;

    assign launch     = r_launch;
    assign launchX    = r_launch_x;
    assign launchY    = r_launch_y;
    assign angle      = w_angle_act;
    assign power      = w_power_act;
    assign player     = r_player;
    assign phase      = r_state;
    assign timeout    = r_timeout;
    assign turn_count = r_turn_count;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_AIM;
        else       r_state <= w_state_nxt;
    end

    // Next state, aim auto-repeat, flight/settle counting and turn bookkeeping
    always_comb begin
        w_state_nxt      = r_state;
        w_ang_rpt_nxt    = r_ang_rpt;
        w_pwr_rpt_nxt    = r_pwr_rpt;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_seen_low_nxt   = r_seen_low;
        w_angle_new      = w_angle_act;
        w_power_new      = w_power_act;
        w_angle0_nxt     = r_angle0;
        w_angle1_nxt     = r_angle1;
        w_power0_nxt     = r_power0;
        w_power1_nxt     = r_power1;
        w_player_nxt     = r_player;
        w_turn_count_nxt = r_turn_count;
        w_launch_x_nxt   = r_launch_x;
        w_launch_y_nxt   = r_launch_y;
        w_timeout_nxt    = 1'b0;
        w_launch_nxt     = 1'b0;

        unique case (r_state)
            S_AIM: begin
                if (frame_tick) begin
                    if (w_ang_single) begin
                        if (r_ang_rpt == '0) begin
                            w_ang_rpt_nxt = RPT_W'(KEY_REPEAT - 1);
                            if (ang_up && (w_angle_act < ANGLE_MAX))
                                w_angle_new = w_angle_act + 4'd1;
                            else if (ang_dn && (w_angle_act != 4'd0))
                                w_angle_new = w_angle_act - 4'd1;
                        end else begin
                            w_ang_rpt_nxt = r_ang_rpt - RPT_W'(1);
                        end
                    end else begin
                        w_ang_rpt_nxt = '0;
                    end
                    if (w_pwr_single) begin
                        if (r_pwr_rpt == '0) begin
                            w_pwr_rpt_nxt = RPT_W'(KEY_REPEAT - 1);
                            if (pwr_up && (w_power_act < POWER_MAX))
                                w_power_new = w_power_act + 3'd1;
                            else if (pwr_dn && (w_power_act != 3'd0))
                                w_power_new = w_power_act - 3'd1;
                        end else begin
                            w_pwr_rpt_nxt = r_pwr_rpt - RPT_W'(1);
                        end
                    end else begin
                        w_pwr_rpt_nxt = '0;
                    end
                end
                if (w_fire_edge) begin
                    w_state_nxt    = S_LAUNCH;
                    w_launch_x_nxt = r_player ? tank1_x : tank0_x;
                    w_launch_y_nxt = r_player ? tank1_y : tank0_y;
                end
            end
            S_LAUNCH: begin
                // the bomb samples launch on this frame tick
                if (frame_tick) w_state_nxt = S_FLIGHT;
            end
            S_FLIGHT: begin
                if (!exploded) w_seen_low_nxt = 1'b1;
                if (w_boom) begin
                    w_state_nxt = S_SETTLE;
                end else if (frame_tick) begin
                    if (r_frame_cnt == FRM_W'(MAX_FLIGHT - 1)) begin
                        w_state_nxt   = S_SETTLE;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FRM_W'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (frame_tick) begin
                    if (r_frame_cnt == FRM_W'(SETTLE_FRAMES - 1))
                        w_state_nxt = S_SWAP;
                    else
                        w_frame_cnt_nxt = r_frame_cnt + FRM_W'(1);
                end
            end
            S_SWAP: begin
                w_player_nxt     = ~r_player;
                w_turn_count_nxt = r_turn_count + 8'd1;
                w_state_nxt      = S_AIM;
            end
            default: w_state_nxt = S_AIM;
        endcase

        // only the active player's aim registers move
        if (r_player) begin
            w_angle1_nxt = w_angle_new;
            w_power1_nxt = w_power_new;
        end else begin
            w_angle0_nxt = w_angle_new;
            w_power0_nxt = w_power_new;
        end

        // every phase starts with fresh counters
        if (w_state_nxt != r_state) begin
            w_ang_rpt_nxt   = '0;
            w_pwr_rpt_nxt   = '0;
            w_frame_cnt_nxt = '0;
            w_seen_low_nxt  = 1'b0;
        end

        w_launch_nxt = (w_state_nxt == S_LAUNCH);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fire_prev  <= 1'b0;
            r_ang_rpt    <= '0;
            r_pwr_rpt    <= '0;
            r_frame_cnt  <= '0;
            r_seen_low   <= 1'b0;
            r_angle0     <= 4'(ANGLE_P0);
            r_angle1     <= 4'(ANGLE_P1);
            r_power0     <= 3'(POWER_INIT);
            r_power1     <= 3'(POWER_INIT);
            r_player     <= 1'b0;
            r_turn_count <= 8'd0;
            r_launch     <= 1'b0;
            r_launch_x   <= 10'd0;
            r_launch_y   <= 10'd0;
            r_timeout    <= 1'b0;
        end else begin
            r_fire_prev  <= fire;
            r_ang_rpt    <= w_ang_rpt_nxt;
            r_pwr_rpt    <= w_pwr_rpt_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_seen_low   <= w_seen_low_nxt;
            r_angle0     <= w_angle0_nxt;
            r_angle1     <= w_angle1_nxt;
            r_power0     <= w_power0_nxt;
            r_power1     <= w_power1_nxt;
            r_player     <= w_player_nxt;
            r_turn_count <= w_turn_count_nxt;
            r_launch     <= w_launch_nxt;
            r_launch_x   <= w_launch_x_nxt;
            r_launch_y   <= w_launch_y_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

endmodule
